writeback_buffer: RTL

- Write-side front end of the register file: collects results from execution/load units over a valid/ready handshake.
- Queues them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's writeReg/writeData/regWrite inputs.
- Provides combinational forwarding lookups so decode can read values still pending in the buffer.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/wb_fwd_match.sv | 31 +++
 rtl/writeback_buffer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths, the hard-wired zero register and
// the layout of one pending register-file write.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority match of one lookup address against N write candidates; candidate 0
// is the youngest and wins over every higher index.
module wb_fwd_match #(
  parameter int N    = 5,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]     addr,
  input  logic [N-1:0]      candValid,
  input  logic [N*AW-1:0]   candRd,
  input  logic [N*XLEN-1:0] candData,
  output logic              hit,
  output logic [XLEN-1:0]   data
);

  // Scan oldest to youngest so the youngest match is the one left standing; x0 never hits.
  always_comb begin
    hit  = 1'b0;
    data = {XLEN{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (candValid[i] && (candRd[i*AW +: AW] == addr) && (addr != {AW{1'b0}})) begin
        hit  = 1'b1;
        data = candData[i*XLEN +: XLEN];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// In-order write-back FIFO in front of the register file: accepts results over
// valid/ready, drains one per cycle, and forwards pending values to decode.
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int AW    = riscv_pkg::AW
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     wb_stall,
  output logic                     regWrite,
  output logic [AW-1:0]            writeReg,
  output logic [XLEN-1:0]          writeData,
  input  logic [AW-1:0]            fwd_addr1,
  input  logic [AW-1:0]            fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NCAND = DEPTH + 1;
  localparam logic [AW-1:0] ZERO_RD = AW'(riscv_pkg::REG_ZERO);

  logic [AW-1:0]    rdMem_r   [DEPTH];
  logic [XLEN-1:0]  dataMem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             regWrite_r;
  logic [AW-1:0]    writeReg_r;
  logic [XLEN-1:0]  writeData_r;

  logic             full_s;
  logic             empty_s;
  logic             store_s;
  logic             pop_s;

  logic [NCAND-1:0]      candValid_s;
  logic [NCAND*AW-1:0]   candRd_s;
  logic [NCAND*XLEN-1:0] candData_s;

  // A push to x0 completes the handshake but is never stored.
  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign store_s  = in_valid && !full_s && (in_rd != ZERO_RD);
  assign pop_s    = !empty_s && !wb_stall;

  assign in_ready  = !full_s;
  assign count     = count_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign regWrite  = regWrite_r;
  assign writeReg  = writeReg_r;
  assign writeData = writeData_r;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (store_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({store_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so no stale value can ever be forwarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rdMem_r[i]   <= {AW{1'b0}};
        dataMem_r[i] <= {XLEN{1'b0}};
      end
    end else if (store_s) begin
      rdMem_r[tail_r]   <= in_rd;
      dataMem_r[tail_r] <= in_data;
    end
  end

  // Register-file write port: strobe for one cycle per pop, address/data hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regWrite_r  <= 1'b0;
      writeReg_r  <= {AW{1'b0}};
      writeData_r <= {XLEN{1'b0}};
    end else begin
      regWrite_r <= pop_s;
      if (pop_s) begin
        writeReg_r  <= rdMem_r[head_r];
        writeData_r <= dataMem_r[head_r];
      end
    end
  end

  // Candidate k is the k-th youngest queue entry; the output register comes last.
  for (genvar k = 0; k < DEPTH; k++) begin : g_cand
    logic [PTR_W-1:0] slot_s;
    assign slot_s                          = tail_r - PTR_W'(k + 1);
    assign candValid_s[k]                  = (CNT_W'(k) < count_r);
    assign candRd_s[k*AW +: AW]            = rdMem_r[slot_s];
    assign candData_s[k*XLEN +: XLEN]      = dataMem_r[slot_s];
  end

  assign candValid_s[DEPTH]               = regWrite_r;
  assign candRd_s[DEPTH*AW +: AW]         = writeReg_r;
  assign candData_s[DEPTH*XLEN +: XLEN]   = writeData_r;

  wb_fwd_match #(.N(NCAND), .XLEN(XLEN), .AW(AW)) u_fwd1 (
    .addr      (fwd_addr1),
    .candValid (candValid_s),
    .candRd    (candRd_s),
    .candData  (candData_s),
    .hit       (fwd_hit1),
    .data      (fwd_data1)
  );

  wb_fwd_match #(.N(NCAND), .XLEN(XLEN), .AW(AW)) u_fwd2 (
    .addr      (fwd_addr2),
    .candValid (candValid_s),
    .candRd    (candRd_s),
    .candData  (candData_s),
    .hit       (fwd_hit2),
    .data      (fwd_data2)
  );

endmodule
